// File: rtl/player_ctrl.sv
// player_ctrl -- player sprite controller for a scrolling shooter.
//
// Moves a sprite on a divided movement tick from held direction keys,
// clamps it to the visible area, and runs a three-state life machine:
// ALIVE -> (hit) -> INVULN (blinking, hit-immune) -> ALIVE, or DEAD when
// the last life is lost. gameover freezes everything except the tick
// counter.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   btnstate  held keys: [0] up, [1] down, [2] left, [3] right
//   slow      focus mode, selects SLOW_SPEED
//   hit       one-cycle collision pulse
//   gameover  freeze request
//   pos_x     sprite top-left x (registered)
//   pos_y     sprite top-left y (registered)
//   lives     remaining lives (registered)
//   invuln    high in INVULN (registered)
//   visible   sprite draw enable (registered)
//   dead      high in DEAD (registered)
module player_ctrl #(
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int H_MAX      = 639,
    parameter int V_MAX      = 479,
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 32,
    parameter int START_X    = 304,
    parameter int START_Y    = 400,
    parameter int SPEED      = 4,
    parameter int SLOW_SPEED = 1,
    parameter int TICK_DIV   = 4194304,
    parameter int LIVES      = 3,
    parameter int INV_TICKS  = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     btnstate,
    input  logic           slow,
    input  logic           hit,
    input  logic           gameover,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic [1:0]     lives,
    output logic           invuln,
    output logic           visible,
    output logic           dead
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(INV_TICKS + 1);

    // Movement limits in the extended (one extra bit, signed) domain.
    localparam logic signed [X_W:0] X_LIM = (X_W+1)'(H_MAX + 1 - SPR_W);
    localparam logic signed [Y_W:0] Y_LIM = (Y_W+1)'(V_MAX + 1 - SPR_H);

    typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [IW-1:0]   inv_cnt_q, inv_cnt_d;
    logic [X_W-1:0]  pos_x_q, pos_x_d;
    logic [Y_W-1:0]  pos_y_q, pos_y_d;
    logic [1:0]      lives_q, lives_d;
    logic            visible_q, visible_d;
    logic            invuln_q, invuln_d;
    logic            dead_q, dead_d;

    logic            tick;
    logic signed [X_W:0] step_x, dx, nx;
    logic signed [Y_W:0] step_y, dy, ny;

    // A negative intermediate means a decrement went past 0: pin to 0.
    function automatic logic [X_W-1:0] sat_x(input logic signed [X_W:0] v);
        if (v < 0)          sat_x = '0;
        else if (v > X_LIM) sat_x = X_LIM[X_W-1:0];
        else                sat_x = v[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] sat_y(input logic signed [Y_W:0] v);
        if (v < 0)          sat_y = '0;
        else if (v > Y_LIM) sat_y = Y_LIM[Y_W-1:0];
        else                sat_y = v[Y_W-1:0];
    endfunction

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    // Candidate next position; opposing keys cancel on their axis.
    always_comb begin
        step_x = slow ? (X_W+1)'(SLOW_SPEED) : (X_W+1)'(SPEED);
        step_y = slow ? (Y_W+1)'(SLOW_SPEED) : (Y_W+1)'(SPEED);
        case ({btnstate[3], btnstate[2]})
            2'b10:   dx = step_x;
            2'b01:   dx = -step_x;
            default: dx = '0;
        endcase
        case ({btnstate[1], btnstate[0]})
            2'b10:   dy = step_y;
            2'b01:   dy = -step_y;
            default: dy = '0;
        endcase
        nx = $signed({1'b0, pos_x_q}) + dx;
        ny = $signed({1'b0, pos_y_q}) + dy;
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        inv_cnt_d  = inv_cnt_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        lives_d    = lives_q;
        visible_d  = visible_q;

        if (!gameover) begin
            case (state_q)
                ALIVE: begin
                    visible_d = 1'b1;
                    if (hit) begin
                        // Hit wins over a coincident tick: no movement.
                        visible_d = 1'b0;
                        if (lives_q > 2'd1) begin
                            lives_d   = lives_q - 2'd1;
                            pos_x_d   = X_W'(START_X);
                            pos_y_d   = Y_W'(START_Y);
                            inv_cnt_d = IW'(INV_TICKS);
                            state_d   = INVULN;
                        end else begin
                            lives_d = 2'd0;
                            state_d = DEAD;
                        end
                    end else if (tick) begin
                        pos_x_d = sat_x(nx);
                        pos_y_d = sat_y(ny);
                    end
                end
                INVULN: begin
                    if (tick) begin
                        pos_x_d = sat_x(nx);
                        pos_y_d = sat_y(ny);
                        if (inv_cnt_q <= IW'(1)) begin
                            inv_cnt_d = '0;
                            visible_d = 1'b1;
                            state_d   = ALIVE;
                        end else begin
                            inv_cnt_d = inv_cnt_q - 1'b1;
                            visible_d = ~visible_q;
                        end
                    end
                end
                default: begin
                    visible_d = 1'b0;
                end
            endcase
        end

        invuln_d = (state_d == INVULN);
        dead_d   = (state_d == DEAD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ALIVE;
            tick_cnt_q <= '0;
            inv_cnt_q  <= '0;
            pos_x_q    <= X_W'(START_X);
            pos_y_q    <= Y_W'(START_Y);
            lives_q    <= 2'(LIVES);
            visible_q  <= 1'b1;
            invuln_q   <= 1'b0;
            dead_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            lives_q    <= lives_d;
            visible_q  <= visible_d;
            invuln_q   <= invuln_d;
            dead_q     <= dead_d;
        end
    end

    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;
    assign lives   = lives_q;
    assign invuln  = invuln_q;
    assign visible = visible_q;
    assign dead    = dead_q;

endmodule
